// File: rtl/move_input_conditioner_pkg.sv
// rtl/move_input_conditioner_pkg.sv - direction codes, timing defaults and arbitration helper for the move input conditioner
package move_input_conditioner_pkg;

    // Number of board switches feeding the conditioner.
    localparam int NUM_SW = 4;

    // Direction codes shared with the frog controller.
    typedef logic [1:0] dir_t;
    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

    // 10 ms of stable input at 25 MHz before a level change is believed.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;

`ifdef AUTO_REPEAT_EN
    // 500 ms before the first repeat, then one repeat every 200 ms.
    localparam int unsigned DEFAULT_REPEAT_DELAY_CYCLES  = 12500000;
    localparam int unsigned DEFAULT_REPEAT_PERIOD_CYCLES = 5000000;
`endif

    // Fixed priority pick: up beats down beats left beats right.
    function automatic dir_t pick_dir(input logic [NUM_SW-1:0] req);
        dir_t d;
        if (req[0]) begin
            d = DIR_UP;
        end else if (req[1]) begin
            d = DIR_DOWN;
        end else if (req[2]) begin
            d = DIR_LEFT;
        end else begin
            d = DIR_RIGHT;
        end
        return d;
    endfunction

endpackage

// File: rtl/move_input_conditioner_switch_debouncer.sv
// rtl/move_input_conditioner_switch_debouncer.sv - 2-FF synchroniser, debounce counter, debounced level and rise pulse for one switch
module move_input_conditioner_switch_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_in,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    // Count consecutive disagreeing cycles; flip the level once the disagreement has lasted long enough.
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        cnt_inc = cnt_q + 1'b1;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_inc == CNT_DONE) begin
                cnt_d   = '0;
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State registers; the rise pulse is registered alongside the level it describes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/move_input_conditioner.sv
// rtl/move_input_conditioner.sv - debounced, coalesced, priority-arbitrated move commands from four switches (optional AUTO_REPEAT_EN)
module move_input_conditioner
    import move_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef AUTO_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY_CYCLES  = DEFAULT_REPEAT_DELAY_CYCLES,
    parameter int unsigned REPEAT_PERIOD_CYCLES = DEFAULT_REPEAT_PERIOD_CYCLES
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       switch1,
    input  logic       switch2,
    input  logic       switch3,
    input  logic       switch4,
    output logic       move_valid,
    output logic [1:0] move_dir,
    input  logic       move_ready,
    output logic [3:0] switch_level
);

    logic [NUM_SW-1:0] raw_sw;
    logic [NUM_SW-1:0] level;
    logic [NUM_SW-1:0] rise;
    logic [NUM_SW-1:0] repeat_evt;

    logic [NUM_SW-1:0] pending_q, pending_d;
    logic [NUM_SW-1:0] pending_clr;
    logic              move_valid_q, move_valid_d;
    dir_t              move_dir_q, move_dir_d;
    logic              grant_en;
    dir_t              grant_dir;

    assign raw_sw = {switch4, switch3, switch2, switch1};

    for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
        move_input_conditioner_switch_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .raw_in (raw_sw[i]),
            .level  (level[i]),
            .rise   (rise[i])
        );
    end

`ifdef AUTO_REPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                       REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] DELAY_CNT  = HOLD_W'(REPEAT_DELAY_CYCLES);
    localparam logic [HOLD_W-1:0] PERIOD_CNT = HOLD_W'(REPEAT_PERIOD_CYCLES);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0] hold_target;
    logic              repeating_q, repeating_d;
    logic              one_held;

    assign one_held = $onehot(level);

    // Time a single held switch: first repeat after the delay, later ones every period.
    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        repeating_d = repeating_q;
        repeat_evt  = '0;
        hold_target = repeating_q ? PERIOD_CNT : DELAY_CNT;
        if (!one_held) begin
            hold_cnt_d  = '0;
            repeating_d = 1'b0;
        end else if (hold_cnt_q == hold_target) begin
            repeat_evt  = level;
            hold_cnt_d  = HOLD_W'(1);
            repeating_d = 1'b1;
        end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    // Hold-timer registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_cnt_q  <= '0;
            repeating_q <= 1'b0;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            repeating_q <= repeating_d;
        end
    end
`else
    assign repeat_evt = '0;
`endif

    // Grant the highest-priority pending move whenever the output slot is free or being emptied.
    always_comb begin
        grant_en     = !move_valid_q || move_ready;
        grant_dir    = pick_dir(pending_q);
        pending_clr  = '0;
        move_valid_d = move_valid_q;
        move_dir_d   = move_dir_q;
        if (grant_en) begin
            if (|pending_q) begin
                move_valid_d = 1'b1;
                move_dir_d   = grant_dir;
                pending_clr  = NUM_SW'(1) << grant_dir;
            end else begin
                move_valid_d = 1'b0;
            end
        end
        // A fresh event on the direction being granted survives the clear.
        pending_d = (pending_q & ~pending_clr) | rise | repeat_evt;
    end

    // Pending set and output register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q    <= '0;
            move_valid_q <= 1'b0;
            move_dir_q   <= DIR_UP;
        end else begin
            pending_q    <= pending_d;
            move_valid_q <= move_valid_d;
            move_dir_q   <= move_dir_d;
        end
    end

    assign move_valid   = move_valid_q;
    assign move_dir     = move_dir_q;
    assign switch_level = level;

endmodule
